// File: rtl/stretch_pkg.sv
// Shared constants for the pulse stretcher: FSM state codes, default flash timing
// and a width-fit helper used by the parameter checks.
package stretch_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int CLK_HZ        = 27000000;
  localparam int ON_TIME_50MS  = 1350000;
  localparam int OFF_TIME_25MS = 675000;

  // True when value is representable in an unsigned field of the given width.
  function automatic logic fits_width(input longint unsigned value, input int unsigned width);
    logic ok_s;
    if (width >= 32'd64) begin
      ok_s = 1'b1;
    end else begin
      ok_s = ((value >> width) == 64'd0);
    end
    return ok_s;
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Indicator-side bundle of the pulse stretcher: hit events in, flash drive and status out.
interface pulse_stretcher_if #(
  parameter int QW = 3
);

  logic          hit;
  logic          stretched;
  logic          busy;
  logic [QW-1:0] pending;
  logic          overflow;

  modport master (
    output hit,
    input  stretched,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  hit,
    output stretched,
    output busy,
    output pending,
    output overflow
  );

endinterface

// File: rtl/pulse_stretcher_chk.sv
// Run-time checks for the pulse stretcher: parameter legality and output consistency.
module pulse_stretcher_chk
  import stretch_pkg::*;
#(
  parameter int ON_TIME   = ON_TIME_50MS,
  parameter int OFF_TIME  = OFF_TIME_25MS,
  parameter int CNT_W     = 21,
  parameter int QUEUE_MAX = 7,
  parameter int QW        = 3
) (
  input logic          clock,
  input logic          reset_n,
  input logic          stretched,
  input logic          busy,
  input logic [QW-1:0] pending,
  input logic          overflow
);

  localparam logic PARAMS_OK =
      (ON_TIME >= 1) && (OFF_TIME >= 1) && (QUEUE_MAX >= 1) &&
      fits_width(longint'(ON_TIME - 1), CNT_W) &&
      fits_width(longint'(OFF_TIME - 1), CNT_W) &&
      fits_width(longint'(QUEUE_MAX), QW);

  a_params_legal : assert property (@(posedge clock) PARAMS_OK);

  a_stretched_busy : assert property (
    @(posedge clock) disable iff (!reset_n) stretched |-> busy);

  a_pending_bound : assert property (
    @(posedge clock) disable iff (!reset_n) (32'(pending) <= QUEUE_MAX));

  a_overflow_saturated : assert property (
    @(posedge clock) disable iff (!reset_n) overflow |-> (32'(pending) == QUEUE_MAX));

endmodule

// File: rtl/pulse_stretcher_rise_detect.sv
// Rising-edge detector; the delayed copy resets high so a level held through reset is ignored.
module rise_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  output logic out_pulse
);

  logic in_d_r;

  // Delayed copy of the input, one cycle behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_d_r <= 1'b1;
    end else begin
      in_d_r <= in;
    end
  end

  assign out_pulse = in & ~in_d_r;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle hits into ON_TIME flashes separated by OFF_TIME dark gaps, queueing
// hits that arrive mid-flash. Define STRETCH_RETRIGGER_EN to let a hit during ON extend the flash.
module pulse_stretcher
  import stretch_pkg::*;
#(
  parameter int ON_TIME   = ON_TIME_50MS,
  parameter int OFF_TIME  = OFF_TIME_25MS,
  parameter int CNT_W     = 21,
  parameter int QUEUE_MAX = 7,
  parameter int QW        = 3
) (
  input logic          clock,
  input logic          reset_n,
  pulse_stretcher_if.slave bus
);

  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_TIME - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD   = CNT_W'(OFF_TIME - 1);
  localparam logic [CNT_W-1:0] TIMER_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);
  localparam logic [QW-1:0]    PEND_ZERO  = {QW{1'b0}};
  localparam logic [QW-1:0]    PEND_ONE   = QW'(1);
  localparam logic [QW-1:0]    PEND_MAX   = QW'(QUEUE_MAX);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_s;
  logic [QW-1:0]    pending_r;
  logic [QW-1:0]    pending_s;
  logic             overflow_r;
  logic             overflow_s;
  logic             stretched_r;
  logic             busy_r;
  logic             rise_s;
  logic             retrig_s;
  logic             enq_s;

  rise_detect u_rise (
    .clock     (clock),
    .reset_n   (reset_n),
    .in        (bus.hit),
    .out_pulse (rise_s)
  );

`ifdef STRETCH_RETRIGGER_EN
  assign retrig_s = rise_s;
`else
  assign retrig_s = 1'b0;
`endif

  // Next-state, timer and pending-queue logic.
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    pending_s  = pending_r;
    overflow_s = 1'b0;
    enq_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_s = ON;
          timer_s = ON_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      ON: begin
        if (retrig_s) begin
          timer_s = ON_LOAD;
        end else begin
          enq_s = rise_s;
          if (timer_r == TIMER_ZERO) begin
            state_s = GAP;
            timer_s = OFF_LOAD;
          end else begin
            timer_s = timer_r - TIMER_ONE;
          end
        end
      end
      GAP: begin
        if (timer_r == TIMER_ZERO) begin
          if (pending_r != PEND_ZERO) begin
            state_s = ON;
            timer_s = ON_LOAD;
            // A hit landing here replaces the one being replayed, so the count holds.
            if (rise_s) begin
              pending_s = pending_r;
            end else begin
              pending_s = pending_r - PEND_ONE;
            end
          end else if (rise_s) begin
            state_s = ON;
            timer_s = ON_LOAD;
          end else begin
            state_s = IDLE;
          end
        end else begin
          timer_s = timer_r - TIMER_ONE;
          enq_s   = rise_s;
        end
      end
      default: begin
        state_s   = IDLE;
        timer_s   = TIMER_ZERO;
        pending_s = PEND_ZERO;
      end
    endcase

    if (enq_s) begin
      if (pending_r == PEND_MAX) begin
        overflow_s = 1'b1;
      end else begin
        pending_s = pending_r + PEND_ONE;
      end
    end else begin
      overflow_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      timer_r     <= TIMER_ZERO;
      pending_r   <= PEND_ZERO;
      overflow_r  <= 1'b0;
      stretched_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      pending_r   <= pending_s;
      overflow_r  <= overflow_s;
      stretched_r <= (state_s == ON);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign bus.stretched = stretched_r;
  assign bus.busy      = busy_r;
  assign bus.pending   = pending_r;
  assign bus.overflow  = overflow_r;

`ifndef SYNTHESIS
  pulse_stretcher_chk #(
    .ON_TIME   (ON_TIME),
    .OFF_TIME  (OFF_TIME),
    .CNT_W     (CNT_W),
    .QUEUE_MAX (QUEUE_MAX),
    .QW        (QW)
  ) u_chk (
    .clock     (clock),
    .reset_n   (reset_n),
    .stretched (stretched_r),
    .busy      (busy_r),
    .pending   (pending_r),
    .overflow  (overflow_r)
  );
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with a flash-schedule reference model and per-cycle compare.
module tb_pulse_stretcher;

  localparam int ON_T  = 4;
  localparam int OFF_T = 3;
  localparam int QMAX  = 3;
  localparam int QW    = 2;
  localparam int CW    = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic hit     = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_stretcher_if #(.QW(QW)) bus ();
  assign bus.hit = hit;

  pulse_stretcher #(
    .ON_TIME   (ON_T),
    .OFF_TIME  (OFF_T),
    .CNT_W     (CW),
    .QUEUE_MAX (QMAX),
    .QW        (QW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Model: flash schedule as remaining lit cycles, remaining dark cycles and a hit count.
  typedef struct {
    int on_left;
    int gap_left;
    int pend;
    bit ovf;
    bit hit_prev;
  } mstate_t;

  function automatic mstate_t model_reset();
    mstate_t r;
    r.on_left = 0; r.gap_left = 0; r.pend = 0; r.ovf = 1'b0; r.hit_prev = 1'b1;
    return r;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input bit h);
    mstate_t n;
    bit rise;
    bit retrig;
    bit enq;
    n = s;
    rise = h && !s.hit_prev;
    retrig = 1'b0;
    enq = 1'b0;
`ifdef STRETCH_RETRIGGER_EN
    retrig = rise;
`endif
    n.hit_prev = h;
    n.ovf = 1'b0;
    if (s.on_left > 0) begin
      if (retrig) n.on_left = ON_T;
      else begin
        n.on_left = s.on_left - 1;
        if (n.on_left == 0) n.gap_left = OFF_T;
        enq = rise;
      end
    end else if (s.gap_left > 0) begin
      n.gap_left = s.gap_left - 1;
      if (s.gap_left == 1) begin
        if (s.pend > 0) begin
          n.on_left = ON_T;
          if (!rise) n.pend = s.pend - 1;
        end else if (rise) n.on_left = ON_T;
      end else enq = rise;
    end else if (rise) n.on_left = ON_T;
    if (enq) begin
      if (n.pend == QMAX) n.ovf = 1'b1;
      else n.pend = n.pend + 1;
    end
    return n;
  endfunction

  mstate_t m = model_reset();

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else m <= model_step(m, hit);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observation counters for hand-computed expectations.
  int hi_cnt, busy_cnt, flashes, ovf_cnt, max_pend, gap_run, min_gap, max_gap;
  logic prev_str = 1'b0;
  logic prev_busy = 1'b0;

  task automatic obs_clear();
    hi_cnt = 0; busy_cnt = 0; flashes = 0; ovf_cnt = 0; max_pend = 0;
    gap_run = 0; min_gap = 1000; max_gap = 0;
  endtask

  always @(negedge clock) begin
    chk("stretched", 32'(bus.stretched), 32'(m.on_left > 0));
    chk("busy", 32'(bus.busy), 32'((m.on_left > 0) || (m.gap_left > 0)));
    chk("pending", 32'(bus.pending), 32'(m.pend));
    chk("overflow", 32'(bus.overflow), 32'(m.ovf));
    if (reset_n) begin
      hi_cnt   += int'(bus.stretched);
      busy_cnt += int'(bus.busy);
      ovf_cnt  += int'(bus.overflow);
      if (int'(bus.pending) > max_pend) max_pend = int'(bus.pending);
      if (bus.stretched && !prev_str) begin
        flashes++;
        if (prev_busy) begin
          if (gap_run < min_gap) min_gap = gap_run;
          if (gap_run > max_gap) max_gap = gap_run;
        end
      end
      if (bus.busy && !bus.stretched) gap_run++;
      else gap_run = 0;
    end
    prev_str  = bus.stretched;
    prev_busy = bus.busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse();
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
  endtask

  initial begin
    obs_clear();
    #1 reset_n = 1'b0;
    tick(3);
    chk("rst_stretched", 32'(bus.stretched), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // Single hit: 4 lit cycles, 7 busy cycles.
    obs_clear();
    tick(3);
    pulse();
    chk("t1_latency", 32'(bus.stretched), 32'd1);
    tick(20);
    chk("t1_high", 32'(hi_cnt), 32'd4);
    chk("t1_busy", 32'(busy_cnt), 32'd7);
    chk("t1_flashes", 32'(flashes), 32'd1);
    chk("t1_maxpend", 32'(max_pend), 32'd0);

    // Held level counts once.
    obs_clear();
    hit = 1'b1;
    tick(20);
    hit = 1'b0;
    tick(10);
    chk("t2_high", 32'(hi_cnt), 32'd4);
    chk("t2_flashes", 32'(flashes), 32'd1);
    chk("t2_maxpend", 32'(max_pend), 32'd0);

    // Three hits two cycles apart: queued and replayed with 3-cycle gaps.
    obs_clear();
    pulse(); tick(1); pulse(); tick(1); pulse();
    tick(30);
`ifndef STRETCH_RETRIGGER_EN
    chk("t3_flashes", 32'(flashes), 32'd3);
    chk("t3_high", 32'(hi_cnt), 32'd12);
    chk("t3_maxpend", 32'(max_pend), 32'd2);
    chk("t3_mingap", 32'(min_gap), 32'd3);
    chk("t3_maxgap", 32'(max_gap), 32'd3);
`endif
    chk("t3_end_pending", 32'(bus.pending), 32'd0);

    // Six hits two cycles apart: saturation at 3 and one dropped hit.
    obs_clear();
    repeat (6) begin
      pulse();
      tick(1);
    end
    tick(40);
`ifndef STRETCH_RETRIGGER_EN
    chk("t4_flashes", 32'(flashes), 32'd5);
    chk("t4_overflow", 32'(ovf_cnt), 32'd1);
    chk("t4_maxpend", 32'(max_pend), 32'd3);
    chk("t4_high", 32'(hi_cnt), 32'd20);
`endif

    // Hit in the terminal gap cycle with nothing queued.
    obs_clear();
    pulse(); tick(6); pulse();
    chk("t5a_on", 32'(bus.stretched), 32'd1);
    chk("t5a_pending", 32'(bus.pending), 32'd0);
    tick(15);
    chk("t5a_flashes", 32'(flashes), 32'd2);
    chk("t5a_gap", 32'(min_gap), 32'd3);
    chk("t5a_maxgap", 32'(max_gap), 32'd3);

    // Hit in the terminal gap cycle with one queued.
    obs_clear();
    pulse(); tick(1); pulse(); tick(4); pulse();
`ifndef STRETCH_RETRIGGER_EN
    chk("t5b_pending", 32'(bus.pending), 32'd1);
    chk("t5b_on", 32'(bus.stretched), 32'd1);
`endif
    tick(25);
`ifndef STRETCH_RETRIGGER_EN
    chk("t5b_flashes", 32'(flashes), 32'd3);
    chk("t5b_maxpend", 32'(max_pend), 32'd1);
`endif

    // Reset mid-ON with two queued, hit held through release.
    pulse(); tick(1); pulse(); tick(1); pulse();
    tick(3);
    pulse();
    hit = 1'b1;
    tick(1);
`ifndef STRETCH_RETRIGGER_EN
    chk("t6_pending_before", 32'(bus.pending), 32'd2);
`endif
    chk("t6_on_before", 32'(bus.stretched), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_stretched", 32'(bus.stretched), 32'd0);
    chk("t6_async_busy", 32'(bus.busy), 32'd0);
    chk("t6_async_pending", 32'(bus.pending), 32'd0);
    obs_clear();
    tick(2);
    reset_n = 1'b1;
    tick(12);
    chk("t6_no_flash", 32'(flashes), 32'd0);
    chk("t6_no_high", 32'(hi_cnt), 32'd0);
    hit = 1'b0;
    tick(3);

    // Hit on the third lit cycle.
    obs_clear();
    pulse(); tick(2); pulse();
    tick(25);
`ifdef STRETCH_RETRIGGER_EN
    chk("t7_high", 32'(hi_cnt), 32'd7);
    chk("t7_flashes", 32'(flashes), 32'd1);
`else
    chk("t7_high", 32'(hi_cnt), 32'd8);
    chk("t7_flashes", 32'(flashes), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
